seq_monitor: RTL and testbench

SEQ_MONITOR -- requirements
Module: seq_monitor

---
 rtl/seq_monitor_pkg.sv | 18 +
 rtl/seq_step_delay.sv | 47 ++++
 rtl/seq_monitor.sv | 112 +++++++++++
 tb/tb_seq_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_monitor_pkg.sv
// Shared constants and helpers for the temporal sequence monitor.
package seq_monitor_pkg;

  localparam int DEF_NUM_STEPS = 4;
  localparam int DEF_MAX_GAP   = 4;
  localparam int DEF_CNT_W     = 16;

  // A programmed gap of 0 is meaningless (a step cannot be checked in the
  // same cycle as its predecessor), so it is promoted to 1; anything beyond
  // the delay-line depth is pinned to the last tap.
  function automatic int unsigned clamp_gap(input int unsigned gap,
                                            input int unsigned max_gap);
    if (gap == 0)       return 1;
    if (gap > max_gap)  return max_gap;
    return gap;
  endfunction

endpackage

// File: rtl/seq_step_delay.sv
// Token delay line for one sequence step. A token entering on token_in is
// presented on tap exactly gap cycles later; stages past the tap are forced
// empty so a token is never checked twice.
module seq_step_delay #(
  parameter int MAX_GAP = 4,
  parameter int GAP_W   = $clog2(MAX_GAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             token_in,
  input  logic [GAP_W-1:0] gap,      // already clamped to 1..MAX_GAP
  output logic             tap,
  output logic             busy
);

  logic [MAX_GAP-1:0] sr;
  logic [MAX_GAP-1:0] sr_next;

  // Shift tokens forward, dropping whatever leaves the programmed tap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    sr_next    = '0;
    sr_next[0] = token_in;
    for (int i = 1; i < MAX_GAP; i++) begin
      if (i < int'(gap)) sr_next[i] = sr[i-1];
    end
  end

  // Select the stage that corresponds to the programmed delay.
  always_comb begin
    tap = 1'b0;
    for (int i = 0; i < MAX_GAP; i++) begin
      if (i + 1 == int'(gap)) tap = sr[i];
    end
  end

  assign busy = |sr;

  // Token storage; disabling the monitor flushes every in-flight token.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || !enable) sr <= '0;
    else                sr <= sr_next;
  end

endmodule

// File: rtl/seq_monitor.sv
// Overlapping-attempt checker for ev[0] ##g1 ev[1] ... ##gN-1 ev[N-1].
// Each step k>=1 owns a delay line; tokens hop from line to line while the
// matching event is present and die (with a reported failure) when it is not.
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int MAX_GAP   = DEF_MAX_GAP,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GAP_W     = $clog2(MAX_GAP + 1),
  parameter int FS_W      = $clog2(NUM_STEPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [NUM_STEPS-1:0]         ev,
  input  logic [(NUM_STEPS-1)*GAP_W-1:0] gap_cfg,
  output logic                         match_pulse,
  output logic                         fail_pulse,
  output logic [FS_W-1:0]              fail_step,
  output logic [CNT_W-1:0]             match_count,
  output logic [CNT_W-1:0]             fail_count,
  output logic                         active
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_STEPS-2:0][GAP_W-1:0] gap_q;
  logic [NUM_STEPS-1:1]            tap;
  logic [NUM_STEPS-1:1]            busy;
  logic [NUM_STEPS-1:1]            hit;
  logic [NUM_STEPS-1:1]            miss;
  logic [FS_W-1:0]                 fs_d;
  logic [3:0]                      n_fail;
  logic [CNT_W+3:0]                fail_sum;

  // Gap registers follow gap_cfg only while idle so a running check never
  // sees its timing change underneath it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= {(NUM_STEPS-1){GAP_W'(1)}};
    end else if (!enable) begin
      for (int k = 0; k < NUM_STEPS - 1; k++) begin
        gap_q[k] <= GAP_W'(clamp_gap(32'(gap_cfg[k*GAP_W +: GAP_W]), MAX_GAP));
      end
    end
  end

  for (genvar k = 1; k < NUM_STEPS; k++) begin : g_step
    logic token_in;
    if (k == 1) begin : g_first
      assign token_in = enable & ev[0];
    end else begin : g_next
      assign token_in = hit[k-1];
    end

    assign hit[k]  = enable & tap[k] &  ev[k];
    assign miss[k] = enable & tap[k] & ~ev[k];

    seq_step_delay #(
      .MAX_GAP (MAX_GAP),
      .GAP_W   (GAP_W)
    ) u_delay (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .token_in (token_in),
      .gap      (gap_q[k-1]),
      .tap      (tap[k]),
      .busy     (busy[k])
    );
  end

  assign active = |busy;

  // Lowest failing step wins; count how many attempts died this cycle.
  always_comb begin
    fs_d   = '0;
    n_fail = '0;
    for (int k = NUM_STEPS - 1; k >= 1; k--) begin
      if (miss[k]) fs_d = FS_W'(k);
      n_fail = n_fail + 4'(miss[k]);
    end
    fail_sum = {4'b0, fail_count} + (CNT_W+4)'(n_fail);
  end

  // Registered pulses and saturating counters; clear beats any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_pulse <= 1'b0;
      fail_pulse  <= 1'b0;
      fail_step   <= '0;
      match_count <= '0;
      fail_count  <= '0;
    end else begin
      match_pulse <= hit[NUM_STEPS-1];
      fail_pulse  <= |miss;
      fail_step   <= fs_d;
      if (clear) begin
        match_count <= '0;
        fail_count  <= '0;
      end else begin
        if (hit[NUM_STEPS-1] && match_count != CNT_MAX)
          match_count <= match_count + 1'b1;
        if (fail_sum > {4'b0, CNT_MAX}) fail_count <= CNT_MAX;
        else                            fail_count <= fail_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_monitor.sv
// Directed vector bench for seq_monitor (NUM_STEPS=4, MAX_GAP=4).
module tb_seq_monitor;

  localparam logic [8:0] G1 = 9'b010_001_001;  // gaps {1,1,2}
  localparam logic [8:0] G2 = 9'b111_001_000;  // gaps {0,1,7} -> {1,1,4}

  logic       clk = 1'b0;
  logic       rst, enable, clear;
  logic [3:0] ev;
  logic [8:0] gap_cfg;

  logic        match_pulse, fail_pulse, active;
  logic [1:0]  fail_step;
  logic [15:0] match_count, fail_count;

  logic        s_match_pulse, s_fail_pulse, s_active;
  logic [1:0]  s_fail_step;
  logic [1:0]  s_match_count, s_fail_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_monitor dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ev(ev),
    .gap_cfg(gap_cfg), .match_pulse(match_pulse), .fail_pulse(fail_pulse),
    .fail_step(fail_step), .match_count(match_count),
    .fail_count(fail_count), .active(active)
  );

  seq_monitor #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ev(ev),
    .gap_cfg(gap_cfg), .match_pulse(s_match_pulse), .fail_pulse(s_fail_pulse),
    .fail_step(s_fail_step), .match_count(s_match_count),
    .fail_count(s_fail_count), .active(s_active)
  );

  typedef struct {
    logic       rst, en, clr;
    logic [3:0] ev;
    logic [8:0] gap;
    logic       m, f;
    logic [1:0] fs;
    logic       a;
    int         mc, fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input logic [3:0] v, input logic [8:0] g,
                              input logic m, input logic f, input logic [1:0] fs,
                              input logic a, input int mc, input int fc);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.ev = v; t.gap = g;
    t.m = m; t.f = f; t.fs = fs; t.a = a; t.mc = mc; t.fc = fc;
    return t;
  endfunction

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic [3:0] v, input logic [8:0] g);
    @(negedge clk);
    rst = r; enable = e; clear = c; ev = v; gap_cfg = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic m, input logic f,
                           input logic [1:0] fs, input logic a, input int mc, input int fc);
    check({tag, ".match"}, match_pulse, m);
    check({tag, ".fail"}, fail_pulse, f);
    if (f) check({tag, ".fail_step"}, fail_step, fs);
    check({tag, ".active"}, active, a);
    check({tag, ".match_cnt"}, match_count, mc);
    check({tag, ".fail_cnt"}, fail_count, fc);
    check({tag, ".s_match"}, s_match_pulse, m);
    check({tag, ".s_match_cnt"}, s_match_count, sat3(mc));
    check({tag, ".s_fail_cnt"}, s_fail_count, sat3(fc));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; ev = '0; gap_cfg = G1;

    //              rst en clr ev       gap  m  f  fs    a  mc fc
    // reset, including rst overriding enable/clear/ev, then load gaps {1,1,2}
    vecs.push_back(mk(1, 0, 0, 4'b0000, G1, 0, 0, 2'd0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1111, G1, 0, 0, 2'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, G1, 0, 0, 2'd0, 0, 0, 0));
    // single clean match: ev0 c0, ev1 c1, ev2 c2, ev3 c4
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G1, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, G1, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, G1, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1000, G1, 1, 0, 2'd0, 0, 1, 0));
    // failure at step 2, then at step 1
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G1, 0, 0, 2'd0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, G1, 0, 1, 2'd2, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 4'b0000, G1, 0, 1, 2'd1, 0, 1, 2));
    // match of attempt A and step-2 failure of attempt B in the same cycle
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G1, 0, 0, 2'd0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 4'b0101, G1, 0, 0, 2'd0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G1, 0, 0, 2'd0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 0, 4'b1000, G1, 1, 1, 2'd2, 0, 2, 3));
    // two attempts fail together (steps 1 and 2): count +2, lowest step 1
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 2, 3));
    vecs.push_back(mk(0, 1, 0, 4'b0011, G1, 0, 0, 2'd0, 1, 2, 3));
    vecs.push_back(mk(0, 1, 0, 4'b0000, G1, 0, 1, 2'd1, 0, 2, 5));
    // four overlapping attempts, matches on four consecutive cycles
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 0, 4'b1111, G1, 0, 0, 2'd0, 1, 2, 5));
    vecs.push_back(mk(0, 1, 0, 4'b1110, G1, 1, 0, 2'd0, 1, 3, 5));
    vecs.push_back(mk(0, 1, 0, 4'b1110, G1, 1, 0, 2'd0, 1, 4, 5));
    vecs.push_back(mk(0, 1, 0, 4'b1110, G1, 1, 0, 2'd0, 1, 5, 5));
    vecs.push_back(mk(0, 1, 0, 4'b1110, G1, 1, 0, 2'd0, 0, 6, 5));
    // enable drop with a token at a tap: flushed silently
    vecs.push_back(mk(0, 1, 0, 4'b0001, G1, 0, 0, 2'd0, 1, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G1, 0, 0, 2'd0, 1, 6, 5));
    vecs.push_back(mk(0, 0, 0, 4'b0000, G1, 0, 0, 2'd0, 0, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0000, G1, 0, 0, 2'd0, 0, 6, 5));
    // gap fields 0 and 7 behave as 1 and 4
    vecs.push_back(mk(0, 0, 0, 4'b0000, G2, 0, 0, 2'd0, 0, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0001, G2, 0, 0, 2'd0, 1, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G2, 0, 0, 2'd0, 1, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0100, G2, 0, 0, 2'd0, 1, 6, 5));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 4'b0000, G2, 0, 0, 2'd0, 1, 6, 5));
    vecs.push_back(mk(0, 1, 0, 4'b1000, G2, 1, 0, 2'd0, 0, 7, 5));
    // clear concurrent with a match: clear wins
    vecs.push_back(mk(0, 1, 0, 4'b0001, G2, 0, 0, 2'd0, 1, 7, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G2, 0, 0, 2'd0, 1, 7, 5));
    vecs.push_back(mk(0, 1, 0, 4'b0100, G2, 0, 0, 2'd0, 1, 7, 5));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 4'b0000, G2, 0, 0, 2'd0, 1, 7, 5));
    vecs.push_back(mk(0, 1, 1, 4'b1000, G2, 1, 0, 2'd0, 0, 0, 0));
    // reset mid-flight drops tokens and counts, restores gaps to 1
    vecs.push_back(mk(0, 1, 0, 4'b0001, G2, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0001, G2, 0, 1, 2'd1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1111, G2, 0, 0, 2'd0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0001, G2, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0010, G2, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0100, G2, 0, 0, 2'd0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1000, G2, 1, 0, 2'd0, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].ev, vecs[i].gap);
      check_all($sformatf("v%0d", i), vecs[i].m, vecs[i].f, vecs[i].fs,
                vecs[i].a, vecs[i].mc, vecs[i].fc);
    end

    // gap_cfg changes while enabled are ignored: gaps stay {1,1,1}
    drive(0, 1, 0, 4'b0001, G1);
    drive(0, 1, 0, 4'b0010, G1);
    drive(0, 1, 0, 4'b0100, G1);
    drive(0, 1, 0, 4'b1000, G1);
    check_all("hold_gap", 1, 0, 2'd0, 0, 2, 0);

    // after an idle cycle the new gaps {1,1,2} take effect
    drive(0, 0, 0, 4'b0000, G1);
    drive(0, 1, 0, 4'b0001, G1);
    drive(0, 1, 0, 4'b0010, G1);
    drive(0, 1, 0, 4'b0100, G1);
    drive(0, 1, 0, 4'b0000, G1);
    check_all("load_gap_wait", 0, 0, 2'd0, 1, 2, 0);
    drive(0, 1, 0, 4'b1000, G1);
    check_all("load_gap", 1, 0, 2'd0, 0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
